// File: rtl/regfile_pkg.sv
// Shared constants, index type and read-source select for the register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int XZR_IDX       = 31;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    SEL_STORE = 2'd0,
    SEL_BYP   = 2'd1,
    SEL_ZERO  = 2'd2
  } rd_sel_e;

  // Zero register outranks bypass, so a write aimed at XZR never leaks out.
  function automatic rd_sel_e rd_sel(input logic zero_hit, input logic byp_hit);
    if (zero_hit) return SEL_ZERO;
    if (byp_hit)  return SEL_BYP;
    return SEL_STORE;
  endfunction

endpackage

// File: rtl/regfile_np_mux_n1.sv
// WIDTH-bit N:1 multiplexer with binary select, one instance per read port.
module mux_n1 #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][WIDTH-1:0] din,
  input  logic [SW-1:0]           sel,
  output logic [WIDTH-1:0]        dout
);

  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/regfile_np.sv
// Multi-read-port register file: one write port, bypass, optional zero
// register and optional registered read stage with stall hold.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = XZR_IDX,
  parameter int RD_REG   = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  input  logic                           rd_hold,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data
);

  localparam logic [AW-1:0] ZIDX    = AW'(ZERO_IDX);
  localparam bit            ZERO_ON = (ZERO_EN != 0);

  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic [NUM_RD-1:0][WIDTH-1:0] store_val;
  logic [NUM_RD-1:0][WIDTH-1:0] core_val;
  logic                         wr_zero;

  assign wr_zero = ZERO_ON && (wr_addr == ZIDX);

  always_comb begin
    mem_d = mem_q;
    if (wr_en && !wr_zero) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic             zero_hit;
    logic             byp_hit;
    logic [WIDTH-1:0] core;

    mux_n1 #(
      .WIDTH (WIDTH),
      .N     (DEPTH),
      .SW    (AW)
    ) u_mux (
      .din  (mem_q),
      .sel  (rd_addr[p]),
      .dout (store_val[p])
    );

    // Bypass is suppressed in reset, since that write is discarded.
    always_comb begin
      zero_hit = ZERO_ON && (rd_addr[p] == ZIDX);
      byp_hit  = reset_n && wr_en && (wr_addr == rd_addr[p]);
      case (rd_sel(zero_hit, byp_hit))
        SEL_ZERO: core = '0;
        SEL_BYP:  core = wr_data;
        default:  core = store_val[p];
      endcase
    end

    assign core_val[p] = core;
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_hold ? rd_data_q : core_val;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data = rd_data_q;
  end else begin : g_rd_comb
    logic unused_hold;
    assign unused_hold = rd_hold;
    assign rd_data     = core_val;
  end

endmodule

// File: tb/tb_regfile_np.sv
// Scoreboard bench: four regfile_np configurations driven by directed vectors.
module tb_regfile_np;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Shared stimulus for the three 64x32 two-port instances.
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [63:0]          wr_data;
  logic [1:0][4:0]      rd_addr;
  logic                 rd_hold;
  logic [1:0][63:0]     c_rd, r_rd, n_rd;

  // Stimulus for the 32x16 three-port sweep instance.
  logic                 s_wr_en;
  logic [3:0]           s_wr_addr;
  logic [31:0]          s_wr_data;
  logic [2:0][3:0]      s_rd_addr;
  logic                 s_hold;
  logic [2:0][31:0]     s_rd;

  regfile_np #(.RD_REG(0), .ZERO_EN(1)) u_comb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_hold(rd_hold), .rd_data(c_rd));

  regfile_np #(.RD_REG(1), .ZERO_EN(1)) u_reg (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_hold(rd_hold), .rd_data(r_rd));

  regfile_np #(.RD_REG(0), .ZERO_EN(0)) u_nz (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_hold(rd_hold), .rd_data(n_rd));

  regfile_np #(.WIDTH(32), .DEPTH(16), .NUM_RD(3), .ZERO_EN(1), .ZERO_IDX(15), .RD_REG(0)) u_sw (
    .clk(clk), .reset_n(reset_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr(s_rd_addr), .rd_hold(s_hold), .rd_data(s_rd));

  typedef struct {
    int          dut;
    int          port;
    logic [63:0] val;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int d, input int p);
    case (d)
      0:       return c_rd[p[0]];
      1:       return r_rd[p[0]];
      2:       return n_rd[p[0]];
      default: return {32'b0, s_rd[p[1:0]]};
    endcase
  endfunction

  // Monitor: every cycle, compare each expectation that has come due.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = actual(sb[i].dut, sb[i].port);
        n_cmp++;
        if (sb[i].due < cyc || act !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s: dut%0d port%0d got %h expected %h (cycle %0d)",
                   sb[i].name, sb[i].dut, sb[i].port, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int d, input int p, input logic [63:0] v, input int lat,
                      input string nm);
    exp_t e;
    e.dut  = d;
    e.port = p;
    e.val  = v;
    e.due  = cyc + lat;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic hold);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rd_addr[0] = ra0;
    rd_addr[1] = ra1;
    rd_hold    = hold;
  endtask

  localparam logic [63:0] DB   = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] ONES = {64{1'b1}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    drive(1'b1, 5'd3, 64'hFF, 5'd0, 5'd0, 1'b0);
    s_wr_en   = 1'b0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_rd_addr = '0;
    s_hold    = 1'b0;

    // Reset held two edges with a write to X3 pending; the write must vanish.
    step();
    push(0, 0, 64'h0, 0, "rst_hold_read");
    step();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd0, 1'b0);
    push(0, 0, 64'h0, 0, "rst_comb_x3");
    push(2, 0, 64'h0, 0, "rst_nz_x3");
    push(1, 0, 64'h0, 0, "rst_reg_out");
    push(1, 0, 64'h0, 1, "rst_reg_x3");

    // Write X5, then read it on both ports.
    step();
    drive(1'b1, 5'd5, DB, 5'd3, 5'd0, 1'b0);
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b0);
    push(0, 0, DB, 0, "wr_rd_p0");
    push(0, 1, DB, 0, "wr_rd_p1");
    push(2, 0, DB, 0, "wr_rd_nz_p0");
    push(1, 0, DB, 1, "wr_rd_reg_p0");
    push(1, 1, DB, 1, "wr_rd_reg_p1");

    // X7 = 1, then overwrite with 2 while port 1 reads X7.
    step();
    drive(1'b1, 5'd7, 64'h1, 5'd5, 5'd5, 1'b0);
    step();
    drive(1'b1, 5'd7, 64'h2, 5'd5, 5'd7, 1'b0);
    push(0, 1, 64'h2, 0, "byp_comb");
    push(2, 1, 64'h2, 0, "byp_nz");
    push(0, 0, DB, 0, "byp_other_port");
    push(1, 1, 64'h2, 1, "byp_reg");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd7, 1'b0);
    push(0, 1, 64'h2, 0, "byp_stored");
    push(1, 1, 64'h2, 1, "byp_reg_stored");

    // All-ones to X31: zero register on two instances, plain register on u_nz.
    step();
    drive(1'b1, 5'd31, ONES, 5'd31, 5'd7, 1'b0);
    push(0, 0, 64'h0, 0, "zr_wcyc");
    push(2, 0, ONES, 0, "nz_byp");
    push(1, 0, 64'h0, 1, "zr_reg_wcyc");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd31, 5'd7, 1'b0);
    push(0, 0, 64'h0, 0, "zr_next");
    push(2, 0, ONES, 0, "nz_store");
    push(1, 0, 64'h0, 1, "zr_reg_next");

    // Stall hold on the registered instance.
    step();
    drive(1'b1, 5'd4, 64'h44, 5'd31, 5'd7, 1'b0);
    step();
    drive(1'b1, 5'd2, 64'hA, 5'd4, 5'd7, 1'b0);
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd4, 1'b0);
    push(1, 0, 64'hA, 1, "hold_base");
    push(1, 1, 64'h44, 1, "hold_base_p1");
    step();
    drive(1'b1, 5'd2, 64'hB, 5'd4, 5'd4, 1'b1);
    push(1, 0, 64'hA, 1, "hold_c1");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd4, 5'd4, 1'b1);
    push(1, 0, 64'hA, 1, "hold_c2");
    push(0, 0, 64'h44, 0, "comb_ignores_hold");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd4, 5'd4, 1'b1);
    push(1, 0, 64'hA, 1, "hold_c3");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd4, 5'd4, 1'b0);
    push(1, 0, 64'h44, 1, "hold_release");
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd4, 1'b0);
    push(1, 0, 64'hB, 1, "hold_wr_commit");
    push(0, 0, 64'hB, 0, "comb_wr_commit");

    // Parameter sweep instance: register i holds i, X15 is hardwired zero.
    for (int i = 0; i < 16; i++) begin
      step();
      s_wr_en   = 1'b1;
      s_wr_addr = 4'(i);
      s_wr_data = 32'(i);
    end
    step();
    s_wr_en      = 1'b0;
    s_rd_addr[0] = 4'd0;
    s_rd_addr[1] = 4'd9;
    s_rd_addr[2] = 4'd14;
    push(3, 0, 64'd0, 0, "sw_p0_x0");
    push(3, 1, 64'd9, 0, "sw_p1_x9");
    push(3, 2, 64'd14, 0, "sw_p2_x14");
    #1;
    n_cmp++;
    if (s_rd[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL sw_direct_p0: got %h expected 0", s_rd[0]);
    end
    n_cmp++;
    if (s_rd[1] !== 32'd9) begin
      n_bad++;
      $display("FAIL sw_direct_p1: got %h expected 9", s_rd[1]);
    end
    n_cmp++;
    if (s_rd[2] !== 32'd14) begin
      n_bad++;
      $display("FAIL sw_direct_p2: got %h expected e", s_rd[2]);
    end
    step();
    s_rd_addr[0] = 4'd15;
    s_rd_addr[1] = 4'd1;
    s_rd_addr[2] = 4'd8;
    push(3, 0, 64'd0, 0, "sw_zero_x15");
    push(3, 1, 64'd1, 0, "sw_p1_x1");
    push(3, 2, 64'd8, 0, "sw_p2_x8");
    #1;
    n_cmp++;
    if (s_rd[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL sw_direct_x15: got %h expected 0", s_rd[0]);
    end

    // Reset arriving during a stall clears the held output and storage.
    step();
    drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd4, 1'b1);
    reset_n = 1'b0;
    push(1, 0, 64'h0, 1, "rst_over_hold");
    step();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd4, 1'b0);
    push(0, 0, 64'h0, 0, "rst_clears_store");

    step();
    step();
    step();
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never compared (due %0d)", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) $display("FAIL");
    else            $display("PASS");
    $finish;
  end

endmodule

// File: doc/regfile_np.md
Name: regfile_np

Overview:
- Parametrised multi-read-port register file. Successor to the fixed 64-bit, 32:1 read-mux datapath.
- Holds DEPTH x WIDTH architectural registers with one synchronous write port and NUM_RD read ports.
- Has write-to-read bypass, an optional hardwired-zero register, and an optional registered read stage with stall hold.
- Sits in the decode stage of the pipelined CPU, feeding operand latches.

Parameters:
- WIDTH, 64, data bits per register.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- NUM_RD, 2, number of independent read ports; range 1..4.
- ZERO_EN, 1, when 1 register ZERO_IDX always reads 0 and ignores writes.
- ZERO_IDX, 31, index of the hardwired-zero register (XZR).
- RD_REG, 0, read mode. 0 = combinational read. 1 = read data registered, 1-cycle latency.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write register index.
- wr_data  in  WIDTH  write data.
- rd_addr  in  NUM_RD x AW  read indices, one per port.
- rd_hold  in  1  stall. When RD_REG=1, holds rd_data; ignored when RD_REG=0.
- rd_data  out  NUM_RD x WIDTH  read data, one per port.

Behaviour:
- Reset: when reset_n=0 at a clk edge, every register clears to 0, and so do rd_data output registers (RD_REG=1). Any wr_en in that cycle is discarded.
- While reset_n=0 with RD_REG=0, rd_data still reflects storage, which is 0 after the first reset edge.
- Write: if reset_n=1 and wr_en=1 at an edge, reg[wr_addr] <= wr_data. Exception: ZERO_EN=1 and wr_addr=ZERO_IDX, which is silently dropped.
- Read core value per port p, evaluated in priority order:
  - ZERO_EN=1 and rd_addr[p]=ZERO_IDX -> 0.
  - else wr_en=1 and wr_addr=rd_addr[p] -> wr_data (same-cycle bypass).
  - else reg[rd_addr[p]].
- RD_REG=0: rd_data[p] = core value combinationally. Zero cycles of latency.
- RD_REG=1:
  - At each edge with reset_n=1 and rd_hold=0, rd_data[p] <= core value. The data is visible the cycle after the address.
  - rd_hold=1 keeps rd_data unchanged, but register writes still commit.
  - Bypass applies only to the write present in the same cycle as the sampled address. Earlier writes are already in storage.
- Ports are independent; several ports may read the same index simultaneously.
- wr_en=1 with wr_addr=ZERO_IDX still never bypasses, because the zero rule has priority.
- No X propagation: all addresses are in range by construction. DEPTH is a power of two, so there is no out-of-range decode.
- Reset mid-stall: reset wins over rd_hold.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_WIDTH=64, REGFILE_DEPTH=32, XZR_IDX=31;
  - the typedef reg_idx_t (logic [4:0]);
  - a function computing the bypass/zero select.
- One sub-module, mux_n1, is a parametrised WIDTH-bit N:1 mux (N=DEPTH, binary select). It is instantiated once per read port and replaces the fixed 32:1 bit-sliced mux chain.
- Storage and write decode stay in regfile_np.

Test Plan:
1. Reset, then read: hold reset_n=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xFF. Release, read rd_addr[0]=3 -> 0. With RD_REG=1, rd_data is 0 on the cycle after release.
2. Write then read, RD_REG=0: write 0xDEADBEEF_CAFEF00D to X5. Next cycle, rd_addr[0]=5 and rd_addr[1]=5 -> both ports show 0xDEADBEEF_CAFEF00D.
3. Same-cycle bypass: X7 holds 0x1. In one cycle drive wr_en=1, wr_addr=7, wr_data=0x2, rd_addr[1]=7.
   - RD_REG=0: rd_data[1]=0x2 in that cycle.
   - RD_REG=1: rd_data[1]=0x2 on the next cycle.
4. Zero register: write all-ones to X31. Read rd_addr[0]=31 in the write cycle and the following cycle -> 0 both times. Repeat with ZERO_EN=0 -> the bypass returns all-ones, then storage returns all-ones.
5. Stall hold, RD_REG=1: rd_data[0]=0xA from X2. Assert rd_hold for 3 cycles while changing rd_addr[0] to 4 and writing 0xB to X2 -> rd_data[0] stays 0xA. Release -> rd_data[0]=reg[4] on the next cycle. A later read of X2 returns 0xB.
6. Parameter sweep: WIDTH=32, DEPTH=16, NUM_RD=3, ZERO_IDX=15. Write index i to register i for i=0..15, then read all three ports at distinct indices 0, 9 and 14 -> 0, 9 and 14 respectively. Reading 15 -> 0.
